// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared widths, limits and FSM state type for the Booth product accumulator
package booth_pkg;
  localparam int WIDTH   = 5;
  localparam int MAX_LEN = 16;
  localparam int PROD_W  = 2 * WIDTH;
  localparam int ACC_W   = PROD_W + 4;
  localparam int LEN_W   = 5;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;
endpackage

// File: rtl/booth_accum_if.sv
// rtl/booth_accum_if.sv - command, product-input and result handshake bundle of booth_accum
interface booth_accum_if;
  import booth_pkg::*;

  logic              start;
  logic [LEN_W-1:0]  len;
  logic [PROD_W-1:0] prod;
  logic              in_valid;
  logic              in_ready;
  logic [ACC_W-1:0]  acc_out;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              err;

  modport master (
    output start, len, prod, in_valid, out_ready,
    input  in_ready, acc_out, out_valid, busy, err
  );

  modport slave (
    input  start, len, prod, in_valid, out_ready,
    output in_ready, acc_out, out_valid, busy, err
  );
endinterface

// File: rtl/booth_accum_ctrl.sv
// rtl/booth_accum_ctrl.sv - IDLE/ACCUM/HOLD sequencing and remaining-term counter
module booth_accum_ctrl
  import booth_pkg::*;
#(
  parameter int MAX_TERMS = MAX_LEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  input  logic             out_ready,
  output logic             in_ready,
  output logic             out_valid,
  output logic             busy,
  output logic             err,
  output logic             load,
  output logic             take
);

  localparam logic [LEN_W-1:0] MAX_V = LEN_W'(MAX_TERMS);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             err_q, err_d;
  logic             len_ok;

  assign len_ok    = (len != '0) && (len <= MAX_V);
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign take      = in_valid && in_ready;
  assign err       = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    err_d   = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len_ok) begin
            load    = 1'b1;
            rem_d   = len;
            state_d = ACCUM;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ACCUM: begin
        if (take) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) state_d = HOLD;
        end
      end
      HOLD: begin
        // start in this cycle is dropped; IDLE only sees start from its first cycle
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: rtl/booth_accum.sv
// rtl/booth_accum.sv - sums a programmed number of signed Booth products into one result
module booth_accum #(
  parameter int WIDTH   = booth_pkg::WIDTH,
  parameter int MAX_LEN = booth_pkg::MAX_LEN
) (
  input logic          clk,
  input logic          rst,
  booth_accum_if.slave bus
);

  localparam int PROD_W = 2 * WIDTH;
  localparam int ACC_W  = PROD_W + 4;

  logic [ACC_W-1:0] acc;
  logic             load;
  logic             take;

  booth_accum_ctrl #(
    .MAX_TERMS(MAX_LEN)
  ) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .start    (bus.start),
    .len      (bus.len),
    .in_valid (bus.in_valid),
    .out_ready(bus.out_ready),
    .in_ready (bus.in_ready),
    .out_valid(bus.out_valid),
    .busy     (bus.busy),
    .err      (bus.err),
    .load     (load),
    .take     (take)
  );

  // four guard bits cover MAX_LEN worst-case products, so no saturation is needed
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (load) begin
      acc <= '0;
    end else if (take) begin
      acc <= acc + {{(ACC_W-PROD_W){bus.prod[PROD_W-1]}}, bus.prod};
    end
  end

  assign bus.acc_out = acc;
endmodule
